uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver peripheral for the vargen picoRV32 SoC; the receive end of the tx_uart serial stream.
- Deserialises 8N1 frames from the rx_uart pin and buffers received bytes in a small first-word-fall-through FIFO.
- The CPU bus glue pops bytes and reads sticky error flags; a level interrupt feeds one of the irq inputs.
- Target clock is 16 MHz; default divider gives 115200 baud.

Parameters:
- CLK_DIV, 139, clock cycles per bit (16 MHz / 115200, rounded); legal range 8..65535.
- FIFO_LOG2, 2, log2 of FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- rx_uart  in  1  serial input; idle high; asynchronous to clk.
- rd  in  1  pop strobe, one cycle per byte.
- clr_err  in  1  clears the frame_err and overrun flags.
- data_out  out  8  byte at the FIFO head; valid only when valid=1.
- valid  out  1  FIFO not empty.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- irq  out  1  equals valid (level interrupt).

Behaviour:
- Reset values (synchronous, active-high):
  - valid=0, irq=0, frame_err=0, overrun=0, data_out=0.
  - FIFO pointers and count = 0.
  - Both synchroniser flops = 1.
  - FSM = IDLE, bit counter = 0.
- A reset asserted mid-frame aborts the frame; that byte is never pushed.
- rx_uart passes through a 2-flop synchroniser; rxs is the synchronised value.
- Baud counter: 16 bits, counts 0..CLK_DIV-1.
- IDLE:
  - rxs==0 -> START, counter=0.
- START:
  - At counter==CLK_DIV/2-1 (integer divide), sample rxs.
  - rxs==0 -> DATA, counter=0, bit index=0.
  - rxs==1 -> IDLE; treated as a glitch, with no flag and no push.
- DATA:
  - At counter==CLK_DIV-1, sample rxs into shift bit[index]; the first bit received is the LSB.
  - After index 7 is sampled -> STOP, counter=0.
- STOP:
  - At counter==CLK_DIV-1, sample rxs.
  - rxs==1 -> push the byte, go to IDLE.
  - rxs==0 -> discard the byte, set frame_err, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxs==1, then go to IDLE. A break condition therefore yields exactly one frame_err and no bytes.
- Sample points relative to the first clk cycle in which rxs is low:
  - Start bit at +CLK_DIV/2.
  - Data bit n at +CLK_DIV/2+(n+1)*CLK_DIV.
  - Stop bit at +CLK_DIV/2+9*CLK_DIV.
- Push latency: valid and data_out reflect the new byte in the cycle after the stop-bit sample.
- FIFO:
  - Depth 2**FIFO_LOG2; count width FIFO_LOG2+1.
  - data_out is combinational from the head entry.
- rd with valid=1:
  - Pops; the next entry, or valid=0, appears the following cycle.
- rd with valid=0: ignored; no pointer change and no flag.
- Push while full with no pop in the same cycle: the new byte is dropped, overrun is set, and the stored contents are unchanged.
- Push and pop in the same cycle:
  - Both happen and the count is unchanged.
  - No overrun, even when full.
  - When empty, the pushed byte becomes the head the following cycle.
- clr_err clears both sticky flags next cycle. If a set event coincides with clr_err, set wins (flag = 1).
- irq tracks valid with no additional latency.
- The FIFO is not affected by a frame error or an overrun.

Test Plan:
- Reset mid-frame, then idle line:
  - Assert reset for 3 cycles in the middle of a 0x55 frame.
  - Required: valid=0, frame_err=0, overrun=0 after reset. No byte pushed for the aborted frame. The next full frame is received normally.
- Single frame:
  - Send 0xA5 (8N1, 139 clk/bit).
  - Required: valid=1 and data_out=0xA5 the cycle after the stop sample. irq=1.
  - Then rd=1 for 1 cycle. Required: valid=0 next cycle.
- Glitch rejection:
  - Drive rx_uart low for 40 cycles, then high.
  - Required: FSM returns to IDLE, no push, frame_err=0.
- Framing error:
  - Send 0x3C with the stop bit low, holding the line low for 5 bit times, then high.
  - Required: frame_err=1 (once), valid=0.
  - Then pulse clr_err. Required: frame_err=0.
- Overrun:
  - Send 0x01..0x05 back to back with no rd.
  - Required: overrun=1 after the 5th frame. Popping yields 0x01..0x04 and then valid=0.
- Full FIFO, simultaneous push and pop:
  - With 4 bytes stored, pulse rd in the exact cycle the 5th byte (0x77) is pushed.
  - Required: overrun=0, count stays 4, and 0x77 is the last byte read out.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small first-word-fall-through receive FIFO.
// Sticky frame/overrun flags and a level interrupt that mirrors FIFO-not-empty.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV   = 139,
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_uart,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       irq
);
    localparam int unsigned Depth = 2 ** FIFO_LOG2;
    localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BitLast = 16'(CLK_DIV - 1);
    localparam logic [FIFO_LOG2:0] DepthCnt = (FIFO_LOG2 + 1)'(Depth);
    localparam logic [FIFO_LOG2:0] CntOne = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2-1:0] PtrOne = FIFO_LOG2'(1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;

    logic [1:0]  sync_q;
    logic        rxs;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        push, set_ferr;

    logic [7:0]           mem_q [Depth];
    logic [FIFO_LOG2-1:0] wptr_q, rptr_q;
    logic [FIFO_LOG2:0]   count_q;
    logic                 full, do_pop, do_push, drop;
    logic                 frame_err_q, overrun_q;

    assign rxs = sync_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d = StStart;
                    cnt_d   = 16'd0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = 16'd0;
                    idx_d = 3'd0;
                    // A start bit that is high again at mid-bit is a glitch.
                    state_d = rxs ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = 16'd0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitHigh: begin
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign full    = (count_q == DepthCnt);
    assign valid   = (count_q != '0);
    assign do_pop  = rd && valid;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= 8'd0;
        end else begin
            sync_q  <= {sync_q[0], rx_uart};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            if (do_push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + PtrOne;
            end
            if (do_pop) rptr_q <= rptr_q + PtrOne;
            if (do_push && !do_pop) count_q <= count_q + CntOne;
            else if (do_pop && !do_push) count_q <= count_q - CntOne;
            // Set events take priority over a coincident clear.
            frame_err_q <= set_ferr | (frame_err_q & ~clr_err);
            overrun_q   <= drop | (overrun_q & ~clr_err);
        end
    end

    assign data_out  = mem_q[rptr_q];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign irq       = valid;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are modelled into an expected-byte queue,
// and an independent monitor pops and compares on every DUT pop.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int unsigned ClkDiv = 139;
    localparam int unsigned Depth = 4;
    // First rxs-low cycle is two cycles after the line falls; stop sample follows.
    localparam int StopCyc = 2 + ClkDiv / 2 + 9 * ClkDiv;

    logic       clk = 1'b0;
    logic       reset, rx_uart, rd, clr_err;
    logic [7:0] data_out;
    logic       valid, frame_err, overrun, irq;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    bit         exp_ferr, exp_ovr;
    bit         reader_en;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_DIV(ClkDiv), .FIFO_LOG2(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_uart   (rx_uart),
        .rd        (rd),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .irq       (irq)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every cycle in which the DUT pops must deliver the next expected byte.
    always @(negedge clk) begin
        if (rd === 1'b1 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte at %0t",
                         data_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", 32'(data_out), 32'(mon_exp));
            end
        end
    end

    // Consumer with random read latency.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reader_en) rd = valid && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #(95_000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model of one frame's effect on the receive buffer and flags.
    function automatic void model_frame(input logic [7:0] b, input int stop_low,
                                        input bit pop_coincides);
        if (stop_low != 0) exp_ferr = 1'b1;
        else if (exp_q.size() < Depth || pop_coincides) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endfunction

    task automatic send_frame(input logic [7:0] b, input int stop_low);
        rx_uart = 1'b0;
        cyc(ClkDiv);
        for (int i = 0; i < 8; i++) begin
            rx_uart = b[i];
            cyc(ClkDiv);
        end
        if (stop_low != 0) begin
            rx_uart = 1'b0;
            cyc(stop_low * ClkDiv);
        end
        rx_uart = 1'b1;
        cyc(ClkDiv);
    endtask

    task automatic reader_off();
        reader_en = 1'b0;
        rd = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        reader_en = 1'b1;
        while ((exp_q.size() != 0 || valid) && n < 500) begin
            cyc(1);
            n++;
        end
        chk("drain_within_budget", 32'(n < 500), 32'(1));
        reader_off();
        cyc(1);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'(exp_q.size() != 0));
        chk({tag, "_irq"}, 32'(irq), 32'(exp_q.size() != 0));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
        chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int sl;
        reset = 1'b1; rx_uart = 1'b1; rd = 1'b0; clr_err = 1'b0; reader_en = 1'b0;
        @(posedge clk);
        #1;
        cyc(2);
        chk("reset_data_out", 32'(data_out), 32'(0));
        check_state("reset");
        reset = 1'b0;
        cyc(2);

        // Reset in the middle of a 0x55 frame, then idle line.
        rx_uart = 1'b0; cyc(ClkDiv);
        rx_uart = 1'b1; cyc(ClkDiv);
        rx_uart = 1'b0; cyc(ClkDiv);
        rx_uart = 1'b1; cyc(ClkDiv / 2);
        reset = 1'b1; cyc(3); reset = 1'b0;
        cyc(11 * ClkDiv);
        check_state("after_abort");
        model_frame(8'h55, 0, 1'b0);
        reader_en = 1'b1;
        send_frame(8'h55, 0);
        drain();
        check_state("after_55");

        // Single frame with cycle-exact push latency.
        model_frame(8'hA5, 0, 1'b0);
        fork
            send_frame(8'hA5, 0);
            begin
                cyc(StopCyc);
                chk("a5_valid_at_stop_sample", 32'(valid), 32'(0));
                cyc(1);
                chk("a5_valid_after_stop", 32'(valid), 32'(1));
                chk("a5_data_head", 32'(data_out), 32'(8'hA5));
                chk("a5_irq", 32'(irq), 32'(1));
            end
        join
        rd = 1'b1; cyc(1); rd = 1'b0;
        chk("a5_valid_after_pop", 32'(valid), 32'(0));
        chk("a5_irq_after_pop", 32'(irq), 32'(0));

        // Glitch shorter than half a bit.
        rx_uart = 1'b0; cyc(40); rx_uart = 1'b1;
        cyc(2000);
        check_state("glitch");
        b = 8'($urandom);
        model_frame(b, 0, 1'b0);
        reader_en = 1'b1;
        send_frame(b, 0);
        drain();

        // Framing error with the line held low for five bit times.
        model_frame(8'h3C, 5, 1'b0);
        send_frame(8'h3C, 5);
        cyc(10);
        check_state("frame_err_set");
        pulse_clr();
        check_state("frame_err_clr");

        // Overrun: five frames, no reads.
        for (int i = 1; i <= 5; i++) begin
            model_frame(8'(i), 0, 1'b0);
            send_frame(8'(i), 0);
        end
        check_state("overrun_set");
        drain();
        check_state("overrun_drained");
        pulse_clr();
        check_state("overrun_clr");

        // Full FIFO with a pop landing on the same cycle as the push of 0x77.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            model_frame(b, 0, 1'b0);
            send_frame(b, 0);
        end
        check_state("full");
        model_frame(8'h77, 0, 1'b1);
        fork
            send_frame(8'h77, 0);
            begin
                cyc(StopCyc);
                rd = 1'b1;
                cyc(1);
                rd = 1'b0;
            end
        join
        check_state("simul_push_pop");
        drain();
        check_state("simul_drained");

        // Random traffic with occasional bad stop bits and clears.
        reader_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            sl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            model_frame(b, sl, 1'b0);
            send_frame(b, sl);
            cyc($urandom_range(0, 30));
            chk("rand_frame_err", 32'(frame_err), 32'(exp_ferr));
            chk("rand_overrun", 32'(overrun), 32'(exp_ovr));
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
        drain();
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
